// File: rtl/ebpc_pkg.sv
// ebpc_pkg: shared types and code tables for the EBPC bit-plane encoder path.
//   encoding_t  : one variable-length symbol, MSB-aligned in `symbol`; the
//                 bits below `len` are always 0.
//   symb_len_t  : symbol length in bits.
//   Prefix codes: ALL_ONES, DBXZ_DBPNZ, TWO_ONES_PREFIX, SINGLE_ONE_PREFIX,
//                 ZERO_SINGLE, ZRL_PREFIX (a prefix-free set; a leading 1
//                 marks an uncompressed plane).
//   run_symbol(): zero-run symbol for a run length of 1..DEF_MAX_ZRL.
package ebpc_pkg;

    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_BLOCK_SIZE = 8;
    localparam int unsigned DEF_MAX_ZRL    = 4;

    localparam int unsigned LOG2N  = $clog2(DEF_BLOCK_SIZE - 1);
    localparam int unsigned ZRL_W  = $clog2(DEF_MAX_ZRL - 1);
    localparam int unsigned ZCNT_W = $clog2(DEF_MAX_ZRL + 1);

    localparam int unsigned W_PLANE = DEF_BLOCK_SIZE;
    localparam int unsigned W_POS   = 5 + LOG2N;
    localparam int unsigned W_RUN   = 2 + ZRL_W;
    localparam int unsigned W_A     = (W_PLANE > W_POS) ? W_PLANE : W_POS;
    localparam int unsigned SYMB_W  = (W_A > W_RUN) ? W_A : W_RUN;
    localparam int unsigned LEN_W   = $clog2(SYMB_W + 1);

    typedef logic [LEN_W-1:0] symb_len_t;

    typedef struct packed {
        logic [SYMB_W-1:0] symbol;
        symb_len_t         len;
        logic              zero;
    } encoding_t;

    localparam logic [4:0] ALL_ONES          = 5'b00000;
    localparam logic [4:0] DBXZ_DBPNZ        = 5'b00001;
    localparam logic [4:0] TWO_ONES_PREFIX   = 5'b00010;
    localparam logic [4:0] SINGLE_ONE_PREFIX = 5'b00011;
    localparam logic [2:0] ZERO_SINGLE       = 3'b001;
    localparam logic [1:0] ZRL_PREFIX        = 2'b01;

    localparam symb_len_t FIVE           = symb_len_t'(5);
    localparam symb_len_t FIVE_PLUS_LOGN = symb_len_t'(5 + LOG2N);
    localparam symb_len_t N              = symb_len_t'(DEF_BLOCK_SIZE);
    localparam symb_len_t ZERO_LEN       = symb_len_t'(3);
    localparam symb_len_t ZRL_LEN        = symb_len_t'(2 + ZRL_W);

    // A run of one is cheaper as ZERO_SINGLE; longer runs carry r-2.
    function automatic encoding_t run_symbol(input logic [ZCNT_W-1:0] run);
        encoding_t code;
        code      = '0;
        code.zero = 1'b1;
        if (run == ZCNT_W'(1)) begin
            code.symbol[SYMB_W-1 -: 3] = ZERO_SINGLE;
            code.len                   = ZERO_LEN;
        end else begin
            code.symbol[SYMB_W-1 -: 2]     = ZRL_PREFIX;
            code.symbol[SYMB_W-3 -: ZRL_W] = ZRL_W'(run - ZCNT_W'(2));
            code.len                       = ZRL_LEN;
        end
        return code;
    endfunction

endpackage

// File: rtl/dbx_plane_classifier.sv
// dbx_plane_classifier: combinational symbol selection for one bit-plane.
//   dbp_i  : delta bit-plane (BLOCK_SIZE-1 bits)
//   dbx_i  : DBX of the same plane
//   code_o : symbol; a zero DBX yields ZERO_SINGLE with zero=1
// Nonzero planes, first match wins: all ones, DBP zero, single one,
// two adjacent ones, otherwise uncompressed {1, dbx}.
module dbx_plane_classifier
    import ebpc_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE
) (
    input  logic [BLOCK_SIZE-2:0] dbp_i,
    input  logic [BLOCK_SIZE-2:0] dbx_i,
    output encoding_t             code_o
);

    localparam int unsigned PW = BLOCK_SIZE - 1;

    int unsigned      ones;
    int unsigned      msb;
    logic             adjacent;
    logic [LOG2N-1:0] pos;

    always_comb begin
        ones = 0;
        msb  = 0;
        for (int unsigned i = 0; i < PW; i++) begin
            if (dbx_i[i]) begin
                ones = ones + 1;
                msb  = i;
            end
        end
    end

    // With exactly two ones, they are neighbours iff a shifted copy overlaps.
    assign adjacent = (ones == 2) && ((dbx_i & (dbx_i >> 1)) != '0);
    assign pos      = LOG2N'(PW - 1 - msb);

    always_comb begin
        code_o = '0;
        if (dbx_i == '0) begin
            code_o.symbol[SYMB_W-1 -: 3] = ZERO_SINGLE;
            code_o.len                   = ZERO_LEN;
            code_o.zero                  = 1'b1;
        end else if (&dbx_i) begin
            code_o.symbol[SYMB_W-1 -: 5] = ALL_ONES;
            code_o.len                   = FIVE;
        end else if (dbp_i == '0) begin
            code_o.symbol[SYMB_W-1 -: 5] = DBXZ_DBPNZ;
            code_o.len                   = FIVE;
        end else if (ones == 1) begin
            code_o.symbol[SYMB_W-1 -: 5]     = SINGLE_ONE_PREFIX;
            code_o.symbol[SYMB_W-6 -: LOG2N] = pos;
            code_o.len                       = FIVE_PLUS_LOGN;
        end else if (adjacent) begin
            code_o.symbol[SYMB_W-1 -: 5]     = TWO_ONES_PREFIX;
            code_o.symbol[SYMB_W-6 -: LOG2N] = pos;
            code_o.len                       = FIVE_PLUS_LOGN;
        end else begin
            code_o.symbol[SYMB_W-1 -: BLOCK_SIZE] = {1'b1, dbx_i};
            code_o.len                            = N;
        end
    end

endmodule

// File: rtl/dbx_stream_encoder.sv
// dbx_stream_encoder: accepts one block of DATA_W+1 delta bit-planes and
// emits one variable-length symbol per cycle, planes DATA_W down to 0.
//   clk_i, rst_ni             : clock, synchronous active-low reset
//   in_valid_i/in_ready_o     : block handshake (ready only when idle)
//   in_dbp_i[0:DATA_W]        : DBP planes, BLOCK_SIZE-1 bits each
//   out_valid_o/out_ready_i   : symbol handshake, registered output
//   out_code_o, out_last_o    : symbol and end-of-block marker
// Build option DBX_ZRLE_EN: coalesce zero-DBX planes into run symbols of up
// to MAX_ZRL planes; without it each zero plane emits ZERO_SINGLE.
module dbx_stream_encoder
    import ebpc_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int unsigned MAX_ZRL    = DEF_MAX_ZRL
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [0:DATA_W][BLOCK_SIZE-2:0] in_dbp_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output encoding_t                       out_code_o,
    output logic                            out_last_o
);

    localparam int unsigned P_W = $clog2(DATA_W + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ENC   = 2'd1;
`ifdef DBX_ZRLE_EN
    localparam logic [1:0] FLUSH = 2'd2;
    localparam int unsigned Z_W  = $clog2(MAX_ZRL + 1);
`endif

    // Run symbols cannot express MAX_ZRL below 2; such a build is marked
    // by this block in the elaborated hierarchy.
    if (MAX_ZRL < 2) begin : g_max_zrl_unsupported
    end

    logic [1:0]                      state;
    logic [0:DATA_W][BLOCK_SIZE-2:0] dbp;
    logic [0:DATA_W][BLOCK_SIZE-2:0] dbx;
    logic [0:DATA_W][BLOCK_SIZE-2:0] dbx_in;
    logic [P_W-1:0]                  p;
    logic                            advance;
    logic                            at_bottom;
    encoding_t                       plane_code;
`ifdef DBX_ZRLE_EN
    logic [Z_W-1:0]                  zrl;
    logic [Z_W-1:0]                  zrl_inc;
    logic                            plane_zero;
`endif

    always_comb begin
        dbx_in = '0;
        for (int unsigned k = 0; k < DATA_W; k++) begin
            dbx_in[k] = in_dbp_i[k] ^ in_dbp_i[k+1];
        end
        dbx_in[DATA_W] = in_dbp_i[DATA_W];
    end

    dbx_plane_classifier #(
        .BLOCK_SIZE(BLOCK_SIZE)
    ) u_classifier (
        .dbp_i (dbp[p]),
        .dbx_i (dbx[p]),
        .code_o(plane_code)
    );

    // The output register may be reloaded when empty or being consumed.
    assign advance   = !out_valid_o || out_ready_i;
    assign at_bottom = (p == '0);
`ifdef DBX_ZRLE_EN
    assign zrl_inc    = zrl + Z_W'(1);
    assign plane_zero = (dbx[p] == '0);
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            in_ready_o  <= 1'b0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            out_code_o  <= '0;
            p           <= '0;
            dbp         <= '0;
            dbx         <= '0;
`ifdef DBX_ZRLE_EN
            zrl         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    in_ready_o <= 1'b1;
                    if (in_valid_i && in_ready_o) begin
                        dbp        <= in_dbp_i;
                        dbx        <= dbx_in;
                        p          <= P_W'(DATA_W);
`ifdef DBX_ZRLE_EN
                        zrl        <= '0;
`endif
                        in_ready_o <= 1'b0;
                        state      <= ENC;
                    end
                end
                default: begin
                    if (advance) begin
                        if (out_valid_o && out_last_o) begin
                            // Final symbol consumed this cycle.
                            out_valid_o <= 1'b0;
                            out_last_o  <= 1'b0;
                            out_code_o  <= '0;
                            in_ready_o  <= 1'b1;
                            state       <= IDLE;
                        end else begin
`ifdef DBX_ZRLE_EN
                            if (plane_zero) begin
                                // Absorb into the run; flush when full or at plane 0.
                                if (zrl_inc == Z_W'(MAX_ZRL) || at_bottom) begin
                                    out_valid_o <= 1'b1;
                                    out_code_o  <= run_symbol(zrl_inc);
                                    out_last_o  <= at_bottom;
                                    zrl         <= '0;
                                    if (at_bottom) begin
                                        state <= FLUSH;
                                    end
                                end else begin
                                    out_valid_o <= 1'b0;
                                    out_code_o  <= '0;
                                    out_last_o  <= 1'b0;
                                    zrl         <= zrl_inc;
                                end
                                if (!at_bottom) begin
                                    p <= p - P_W'(1);
                                end
                            end else if (zrl != '0) begin
                                // Pending run goes first; p holds so this plane
                                // is encoded on the next accepted cycle.
                                out_valid_o <= 1'b1;
                                out_code_o  <= run_symbol(zrl);
                                out_last_o  <= 1'b0;
                                zrl         <= '0;
                            end else begin
                                out_valid_o <= 1'b1;
                                out_code_o  <= plane_code;
                                out_last_o  <= at_bottom;
                                if (!at_bottom) begin
                                    p <= p - P_W'(1);
                                end
                            end
`else
                            out_valid_o <= 1'b1;
                            out_code_o  <= plane_code;
                            out_last_o  <= at_bottom;
                            if (!at_bottom) begin
                                p <= p - P_W'(1);
                            end
`endif
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbx_stream_encoder.sv
// Directed table-driven bench for dbx_stream_encoder (DATA_W=8,
// BLOCK_SIZE=8, MAX_ZRL=4). Expected symbol lists follow the DBX_ZRLE_EN
// build option.
module tb_dbx_stream_encoder;
    import ebpc_pkg::*;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             in_valid;
    logic             in_ready_o;
    logic [0:8][6:0]  in_dbp;
    logic             out_valid_o;
    logic             out_ready;
    encoding_t        out_code_o;
    logic             out_last_o;

    always #5 clk = ~clk;

    dbx_stream_encoder #(
        .DATA_W    (8),
        .BLOCK_SIZE(8),
        .MAX_ZRL   (4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready_o),
        .in_dbp_i   (in_dbp),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready),
        .out_code_o (out_code_o),
        .out_last_o (out_last_o)
    );

    typedef struct packed {
        logic [0:8][6:0]   dbp;
        logic [3:0]        n;
        encoding_t [0:8]   sym;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    int n_vec = 0;
    int n_err = 0;

    encoding_t e_z1, e_zr4, e_zr3, e_zr2, e_dbxz, e_ones;

    function automatic encoding_t mk(input logic [7:0] s, input logic [3:0] l, input logic z);
        encoding_t e;
        e.symbol = s;
        e.len    = l;
        e.zero   = z;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input int v, input encoding_t e);
        vecs[v].sym[vecs[v].n] = e;
        vecs[v].n = vecs[v].n + 4'd1;
    endtask

    task automatic put_zeros(input int v, input int cnt);
        for (int i = 0; i < cnt; i++) put(v, e_z1);
    endtask

    task automatic run_block(input int v, input int stall_at, input int abort_at,
                             output int first_cyc);
        int k;
        int cyc;
        int wcyc;
        int n;
        n         = int'(vecs[v].n);
        first_cyc = -1;
        wcyc      = 0;
        while (!in_ready_o && wcyc < 20) begin
            @(negedge clk);
            wcyc++;
        end
        check($sformatf("v%0d in_ready_idle", v), in_ready_o, 1);
        in_dbp    = vecs[v].dbp;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 40) begin
            check($sformatf("v%0d in_ready_busy c%0d", v, cyc), in_ready_o, 0);
            if (out_valid_o) begin
                if (first_cyc < 0) first_cyc = cyc;
                check($sformatf("v%0d sym%0d {code,last}", v, k),
                      {out_code_o, out_last_o}, {vecs[v].sym[k], (k == n - 1)});
                if (k == abort_at) begin
                    rst_ni = 1'b0;
                    @(negedge clk);
                    check("reset_mid out_valid", out_valid_o, 0);
                    check("reset_mid out_last", out_last_o, 0);
                    check("reset_mid out_code", out_code_o, 0);
                    check("reset_mid in_ready", in_ready_o, 0);
                    rst_ni = 1'b1;
                    @(negedge clk);
                    check("reset_mid in_ready_after", in_ready_o, 1);
                    return;
                end
                if (k == stall_at) begin
                    out_ready = 1'b0;
                    repeat (5) begin
                        @(negedge clk);
                        check($sformatf("v%0d stall {valid,code,last}", v),
                              {out_valid_o, out_code_o, out_last_o},
                              {1'b1, vecs[v].sym[k], (k == n - 1)});
                        check($sformatf("v%0d stall in_ready", v), in_ready_o, 0);
                    end
                    out_ready = 1'b1;
                end
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        check($sformatf("v%0d symbol_count", v), k, n);
        check($sformatf("v%0d in_ready_after_last", v), in_ready_o, 1);
        check($sformatf("v%0d out_valid_after_last", v), out_valid_o, 0);
    endtask

    initial begin
        int fc;
        rst_ni    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_dbp    = '0;

        e_z1   = mk(8'b001_00000, 4'd3, 1'b1);
        e_zr4  = mk(8'b01_10_0000, 4'd4, 1'b1);
        e_zr3  = mk(8'b01_01_0000, 4'd4, 1'b1);
        e_zr2  = mk(8'b01_00_0000, 4'd4, 1'b1);
        e_dbxz = mk(8'b00001_000, 4'd5, 1'b0);
        e_ones = mk(8'b00000_000, 4'd5, 1'b0);

        for (int i = 0; i < NV; i++) vecs[i] = '0;
        vecs[1].dbp[8] = 7'b0001000;
        vecs[2].dbp[8] = 7'b1010100;
        vecs[3].dbp[8] = 7'b1111111;
        vecs[4].dbp[8] = 7'b0110000;
        vecs[4].dbp[7] = 7'b0110000;
        vecs[5].dbp[0] = 7'b0000001;
        vecs[6].dbp[8] = 7'b1000001;
`ifdef DBX_ZRLE_EN
        put(0, e_zr4); put(0, e_zr4); put(0, e_z1);
        put(1, mk(8'b00011_011, 4'd8, 1'b0)); put(1, e_dbxz); put(1, e_zr4); put(1, e_zr3);
        put(2, mk(8'b1_1010100, 4'd8, 1'b0)); put(2, e_dbxz); put(2, e_zr4); put(2, e_zr3);
        put(3, e_ones); put(3, e_ones); put(3, e_zr4); put(3, e_zr3);
        put(4, mk(8'b00010_001, 4'd8, 1'b0)); put(4, e_z1); put(4, e_dbxz);
        put(4, e_zr4); put(4, e_zr2);
        put(5, e_zr4); put(5, e_zr4); put(5, mk(8'b00011_110, 4'd8, 1'b0));
        put(6, mk(8'b1_1000001, 4'd8, 1'b0)); put(6, e_dbxz); put(6, e_zr4); put(6, e_zr3);
`else
        put_zeros(0, 9);
        put(1, mk(8'b00011_011, 4'd8, 1'b0)); put(1, e_dbxz); put_zeros(1, 7);
        put(2, mk(8'b1_1010100, 4'd8, 1'b0)); put(2, e_dbxz); put_zeros(2, 7);
        put(3, e_ones); put(3, e_ones); put_zeros(3, 7);
        put(4, mk(8'b00010_001, 4'd8, 1'b0)); put(4, e_z1); put(4, e_dbxz); put_zeros(4, 6);
        put_zeros(5, 8); put(5, mk(8'b00011_110, 4'd8, 1'b0));
        put(6, mk(8'b1_1000001, 4'd8, 1'b0)); put(6, e_dbxz); put_zeros(6, 7);
`endif

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset out_valid", out_valid_o, 0);
        check("reset out_last", out_last_o, 0);
        check("reset out_code", out_code_o, 0);
        check("reset in_ready", in_ready_o, 0);
        rst_ni = 1'b1;
        @(negedge clk);
        check("in_ready_first_cycle", in_ready_o, 1);

        // Table of blocks, free-running output.
        for (int v = 0; v < NV; v++) begin
            run_block(v, -1, -1, fc);
            if (v == 1) check("first_symbol_latency", fc, 1);
        end

        // Five-cycle backpressure on the second symbol.
        run_block(1, 1, -1, fc);

        // Reset while the third symbol is presented, then a clean block.
        run_block(1, -1, 2, fc);
        run_block(2, -1, -1, fc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
